// File: rtl/aes2_pkg.sv
// Shared definitions for the AES2 job sequencer: register word offsets,
// sequencer state encoding and byte-address helper.
package aes2_pkg;

    localparam int WORD_BYTES = 4;

    // AES2 word offsets; the plaintext registers run most-significant word first
    localparam logic [5:0] START    = 6'd0;
    localparam logic [5:0] PC3      = 6'd1;
    localparam logic [5:0] PC2      = 6'd2;
    localparam logic [5:0] PC1      = 6'd3;
    localparam logic [5:0] PC0      = 6'd4;
    localparam logic [5:0] CT_VALID = 6'd11;
    localparam logic [5:0] CT0      = 6'd12;
    localparam logic [5:0] CT1      = 6'd13;
    localparam logic [5:0] CT2      = 6'd14;
    localparam logic [5:0] CT3      = 6'd15;
    localparam logic [5:0] KEY_SEL  = 6'd32;

    typedef enum logic [3:0] {
        S_IDLE, S_CLR, S_KSEL, S_PT, S_GO, S_POLL, S_RD, S_STOP, S_DONE
    } state_e;

    function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [5:0] off);
        return base + 32'(off) * 32'(WORD_BYTES);
    endfunction

endpackage

// File: rtl/aes2_job_sequencer_if.sv
// Job, result and register-bus signals of the AES2 job sequencer.
// master = sequencer view, slave = the environment (job source, result sink, AES2).
interface aes2_job_sequencer_if;
    logic         job_valid_i;
    logic         job_ready_o;
    logic [127:0] job_pt_i;
    logic [1:0]   job_ksel_i;
    logic         res_valid_o;
    logic         res_ready_i;
    logic [127:0] res_ct_o;
    logic         res_err_o;
    logic         busy_o;
    logic         bus_valid_o;
    logic         bus_write_o;
    logic [31:0]  bus_addr_o;
    logic [31:0]  bus_wdata_o;
    logic [3:0]   bus_wstrb_o;
    logic [31:0]  bus_rdata_i;
    logic         bus_ready_i;
    logic         bus_error_i;

    modport master (
        input  job_valid_i, job_pt_i, job_ksel_i, res_ready_i,
               bus_rdata_i, bus_ready_i, bus_error_i,
        output job_ready_o, res_valid_o, res_ct_o, res_err_o, busy_o,
               bus_valid_o, bus_write_o, bus_addr_o, bus_wdata_o, bus_wstrb_o
    );

    modport slave (
        output job_valid_i, job_pt_i, job_ksel_i, res_ready_i,
               bus_rdata_i, bus_ready_i, bus_error_i,
        input  job_ready_o, res_valid_o, res_ct_o, res_err_o, busy_o,
               bus_valid_o, bus_write_o, bus_addr_o, bus_wdata_o, bus_wstrb_o
    );
endinterface

// File: rtl/aes2_bus_beat.sv
// Single register-bus transaction holder: loads a request when idle, holds it
// stable until ready, and reports completion, error and read data.
module aes2_bus_beat (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        i_issue,
    input  logic        i_write,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic        i_bus_ready,
    input  logic        i_bus_error,
    input  logic [31:0] i_bus_rdata,
    output logic        o_bus_valid,
    output logic        o_bus_write,
    output logic [31:0] o_bus_addr,
    output logic [31:0] o_bus_wdata,
    output logic [3:0]  o_bus_wstrb,
    output logic        o_done,
    output logic        o_err,
    output logic [31:0] o_rdata
);

    logic        r_valid;
    logic        r_write;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;

    // A request is only taken while idle, so the completion cycle is always
    // followed by one cycle with valid low before the next beat.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid <= 1'b0;
            r_write <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (r_valid) begin
            if (i_bus_ready) r_valid <= 1'b0;
        end else if (i_issue) begin
            r_valid <= 1'b1;
            r_write <= i_write;
            r_addr  <= i_addr;
            r_wdata <= i_wdata;
        end
    end

    assign o_bus_valid = r_valid;
    assign o_bus_write = r_write;
    assign o_bus_addr  = r_addr;
    assign o_bus_wdata = r_wdata;
    assign o_bus_wstrb = (r_valid && r_write) ? 4'hF : 4'h0;
    assign o_done      = r_valid & i_bus_ready;
    assign o_err       = o_done & i_bus_error;
    assign o_rdata     = i_bus_rdata;

endmodule

// File: rtl/aes2_job_sequencer.sv
// Runs one AES2 encryption job: programs key select and plaintext, starts the
// core, polls ct_valid, reads the ciphertext and returns it on the result port.
module aes2_job_sequencer
    import aes2_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          POLL_LIMIT = 1024
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    aes2_job_sequencer_if.master  io
);

    localparam logic [31:0] LIMIT = POLL_LIMIT;

    state_e       r_state, w_next;
    logic [127:0] r_pt;
    logic [1:0]   r_ksel;
    logic [1:0]   r_idx;
    logic [15:0]  r_poll_cnt;
    logic         r_err;
    logic [127:0] r_ct;

    logic         w_issue, w_write, w_done, w_berr, w_timeout;
    logic [5:0]   w_off, w_pc_off, w_ct_off;
    logic [31:0]  w_wdata, w_rdata;
    logic [15:0]  w_poll_inc;

    aes2_bus_beat u_beat (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .i_issue     (w_issue),
        .i_write     (w_write),
        .i_addr      (word_addr(BASE_ADDR, w_off)),
        .i_wdata     (w_wdata),
        .i_bus_ready (io.bus_ready_i),
        .i_bus_error (io.bus_error_i),
        .i_bus_rdata (io.bus_rdata_i),
        .o_bus_valid (io.bus_valid_o),
        .o_bus_write (io.bus_write_o),
        .o_bus_addr  (io.bus_addr_o),
        .o_bus_wdata (io.bus_wdata_o),
        .o_bus_wstrb (io.bus_wstrb_o),
        .o_done      (w_done),
        .o_err       (w_berr),
        .o_rdata     (w_rdata)
    );

    always_comb begin
        case (r_idx)
            2'd0:    begin w_pc_off = PC3; w_ct_off = CT0; end
            2'd1:    begin w_pc_off = PC2; w_ct_off = CT1; end
            2'd2:    begin w_pc_off = PC1; w_ct_off = CT2; end
            default: begin w_pc_off = PC0; w_ct_off = CT3; end
        endcase
    end

    assign w_poll_inc = (&r_poll_cnt) ? r_poll_cnt : r_poll_cnt + 16'd1;
    assign w_timeout  = {16'b0, w_poll_inc} >= LIMIT;

    always_comb begin
        w_next  = r_state;
        w_issue = 1'b0;
        w_write = 1'b1;
        w_off   = START;
        w_wdata = '0;
        case (r_state)
            S_IDLE: if (io.job_valid_i) w_next = S_CLR;
            S_CLR: begin
                w_issue = 1'b1;
                if (w_done) w_next = w_berr ? S_STOP : S_KSEL;
            end
            S_KSEL: begin
                w_issue = 1'b1;
                w_off   = KEY_SEL;
                w_wdata = {30'b0, (r_ksel == 2'd3) ? 2'd2 : r_ksel};
                if (w_done) w_next = w_berr ? S_STOP : S_PT;
            end
            // word 3-idx goes to PC(3-idx), i.e. offset 1+idx
            S_PT: begin
                w_issue = 1'b1;
                w_off   = w_pc_off;
                w_wdata = r_pt[{~r_idx, 5'b0} +: 32];
                if (w_done) begin
                    if (w_berr)              w_next = S_STOP;
                    else if (r_idx == 2'd3)  w_next = S_GO;
                end
            end
            S_GO: begin
                w_issue = 1'b1;
                w_wdata = 32'd1;
                if (w_done) w_next = w_berr ? S_STOP : S_POLL;
            end
            S_POLL: begin
                w_issue = 1'b1;
                w_write = 1'b0;
                w_off   = CT_VALID;
                if (w_done) begin
                    if (w_berr)          w_next = S_STOP;
                    else if (w_rdata[0]) w_next = S_RD;
                    else if (w_timeout)  w_next = S_STOP;
                end
            end
            S_RD: begin
                w_issue = 1'b1;
                w_write = 1'b0;
                w_off   = w_ct_off;
                if (w_done && (w_berr || r_idx == 2'd3)) w_next = S_STOP;
            end
            S_STOP: begin
                w_issue = 1'b1;
                if (w_done) w_next = S_DONE;
            end
            S_DONE: if (io.res_ready_i) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= S_IDLE;
            r_pt       <= '0;
            r_ksel     <= '0;
            r_idx      <= '0;
            r_poll_cnt <= '0;
            r_err      <= 1'b0;
            r_ct       <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && io.job_valid_i) begin
                r_pt       <= io.job_pt_i;
                r_ksel     <= io.job_ksel_i;
                r_idx      <= '0;
                r_poll_cnt <= '0;
                r_err      <= 1'b0;
                r_ct       <= '0;
            end
            if (w_done) begin
                if (w_berr) begin
                    r_err <= 1'b1;
                end else begin
                    case (r_state)
                        S_PT: r_idx <= r_idx + 2'd1;
                        S_RD: begin
                            r_ct[{r_idx, 5'b0} +: 32] <= w_rdata;
                            r_idx <= r_idx + 2'd1;
                        end
                        S_POLL: if (!w_rdata[0]) begin
                            r_poll_cnt <= w_poll_inc;
                            if (w_timeout) r_err <= 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign io.job_ready_o = (r_state == S_IDLE);
    assign io.busy_o      = (r_state != S_IDLE);
    assign io.res_valid_o = (r_state == S_DONE);
    assign io.res_ct_o    = r_ct;
    assign io.res_err_o   = r_err;

endmodule
